// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction fetcher with a small {pc, inst} FIFO
// and redirect flush, feeding the IF stage over a valid/ready handshake.
module inst_prefetch_buffer #(
    parameter int ADDR_LEN = 32,
    parameter int INSTR_LEN = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [ADDR_LEN-1:0]  redirect_pc,
    input  logic                 if_ready,
    output logic                 if_valid,
    output logic [ADDR_LEN-1:0]  if_pc,
    output logic [INSTR_LEN-1:0] if_inst,
    output logic                 mem_req,
    output logic [ADDR_LEN-1:0]  mem_addr,
    input  logic                 mem_ack,
    input  logic [INSTR_LEN-1:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t state_q, state_d;
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_q, count_d;
    logic [ADDR_LEN-1:0] pc_q [DEPTH];
    logic [ADDR_LEN-1:0] pc_d [DEPTH];
    logic [INSTR_LEN-1:0] inst_q [DEPTH];
    logic [INSTR_LEN-1:0] inst_d [DEPTH];
    logic push, pop;

    assign mem_req  = state_q != IDLE;
    assign mem_addr = addr_q;
    assign if_valid = count_q != '0;
    assign if_pc    = pc_q[rd_ptr_q];
    assign if_inst  = inst_q[rd_ptr_q];
    assign push     = state_q == REQ && mem_ack && !redirect_valid;
    assign pop      = if_valid && if_ready && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: if (!redirect_valid && count_q < FULL) begin
                state_d = REQ;
                addr_d  = fetch_pc_q;
            end
            REQ: if (mem_ack) begin
                state_d    = IDLE;
                fetch_pc_d = addr_q + ADDR_LEN'(4);
            end else if (redirect_valid) begin
                state_d = DROP;
            end
            DROP: if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Redirect wins over same-cycle push and pop: the queue simply restarts empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d[wr_ptr_q]   = addr_q;
                inst_d[wr_ptr_q] = mem_rdata;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '{default: '0};
            inst_q   <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb_inst_prefetch_buffer: directed checks of fetch sequencing, FIFO fill/drain,
// redirect flush/drop and async reset, against a simple memory responder.
module tb_inst_prefetch_buffer;
    localparam logic [31:0] KEY = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;
    int lat = 0;
    int wcnt = 0;
    bit mem_auto = 1'b1;
    bit req_prev = 1'b0;
    logic [31:0] req_addrs[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    inst_prefetch_buffer dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_ready(if_ready), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: log the pop about to happen, advance, log new requests, run the memory model.
    task automatic tick();
        if (if_valid && if_ready && !redirect_valid) begin
            got_pc.push_back(if_pc);
            got_inst.push_back(if_inst);
        end
        @(posedge clk);
        #1;
        if (mem_req && !req_prev) req_addrs.push_back(mem_addr);
        req_prev = mem_req;
        if (mem_auto) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_req) begin
                if (wcnt == lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr ^ KEY;
                end else wcnt++;
            end else wcnt = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        redirect_valid = 1'b0;
        wcnt = 0;
        tick();
        tick();
        rst = 1'b0;
        req_prev = 1'b0;
        req_addrs.delete();
        got_pc.delete();
        got_inst.delete();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(mem_req), 64'd1);
    endtask

    task automatic ack_now();
        mem_ack = 1'b1;
        mem_rdata = mem_addr ^ KEY;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic run_until_got(input int want);
        int n = 0;
        while (got_pc.size() < want && n < 100) begin
            tick();
            n++;
        end
        check("got_count", 64'(got_pc.size() >= want), 64'd1);
    endtask

    initial begin
        tick();
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_pc", 64'(if_pc), 64'd0);
        check("rst_inst", 64'(if_inst), 64'd0);

        // 1: latency-2 memory, IF always ready
        mem_auto = 1'b1; lat = 2; if_ready = 1'b1;
        do_reset();
        tick();
        check("t1_req", 64'(mem_req), 64'd1);
        check("t1_addr0", 64'(mem_addr), 64'd0);
        tick(); tick();
        check("t1_ack", 64'(mem_ack), 64'd1);
        check("t1_valid_pre", 64'(if_valid), 64'd0);
        tick();
        check("t1_valid", 64'(if_valid), 64'd1);
        check("t1_pc", 64'(if_pc), 64'd0);
        check("t1_inst", 64'(if_inst), 64'(KEY));
        run_until_got(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_req_addr%0d", i), 64'(req_addrs[i]), 64'(4 * i));
            check($sformatf("t1_pop_pc%0d", i), 64'(got_pc[i]), 64'(4 * i));
            check($sformatf("t1_pop_inst%0d", i), 64'(got_inst[i]), 64'((32'(4 * i)) ^ KEY));
        end

        // 2: fill to DEPTH with IF stalled, then drain
        lat = 1; if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) tick();
        check("t2_nreq", 64'(req_addrs.size()), 64'd4);
        check("t2_req_idle", 64'(mem_req), 64'd0);
        check("t2_valid", 64'(if_valid), 64'd1);
        check("t2_head", 64'(if_pc), 64'd0);
        if_ready = 1'b1;
        run_until_got(4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_pop_pc%0d", i), 64'(got_pc[i]), 64'(4 * i));
        for (int i = 0; i < 20 && req_addrs.size() < 5; i++) tick();
        check("t2_resume", 64'(req_addrs[4]), 64'h10);

        // 3: redirect while REQ for 0x8, stale ack 3 cycles later
        mem_auto = 1'b0; if_ready = 1'b0;
        do_reset();
        wait_req("t3_w0"); ack_now();
        wait_req("t3_w4"); ack_now();
        wait_req("t3_w8");
        check("t3_addr8", 64'(mem_addr), 64'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3_drop_req", 64'(mem_req), 64'd1);
        check("t3_drop_addr", 64'(mem_addr), 64'h8);
        check("t3_flushed", 64'(if_valid), 64'd0);
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check("t3_stale_valid", 64'(if_valid), 64'd0);
        check("t3_stale_req", 64'(mem_req), 64'd0);
        wait_req("t3_w40");
        check("t3_addr40", 64'(mem_addr), 64'h40);
        ack_now();
        check("t3_valid", 64'(if_valid), 64'd1);
        check("t3_pc", 64'(if_pc), 64'h40);
        check("t3_inst", 64'(if_inst), 64'(32'h40 ^ KEY));

        // 4: redirect coinciding with ack and pop
        do_reset();
        wait_req("t4_w0"); ack_now();
        wait_req("t4_w4");
        if_ready = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h4 ^ KEY;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        mem_ack = 1'b0; redirect_valid = 1'b0;
        check("t4_empty", 64'(if_valid), 64'd0);
        check("t4_no_drop", 64'(mem_req), 64'd0);
        tick();
        check("t4_req", 64'(mem_req), 64'd1);
        check("t4_addr", 64'(mem_addr), 64'h80);
        if_ready = 1'b0;
        ack_now();
        check("t4_pc", 64'(if_pc), 64'h80);

        // 5: PC wrap with zero-latency memory
        mem_auto = 1'b1; lat = 0; if_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        run_until_got(3);
        check("t5_pc0", 64'(got_pc[0]), 64'hFFFF_FFF8);
        check("t5_pc1", 64'(got_pc[1]), 64'hFFFF_FFFC);
        check("t5_pc2", 64'(got_pc[2]), 64'h0);
        check("t5_inst2", 64'(got_inst[2]), 64'(KEY));

        // 6: async reset mid-request with two entries queued
        lat = 1; if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 30 && !(req_addrs.size() == 3 && mem_req); i++) tick();
        check("t6_inflight", 64'(mem_req), 64'd1);
        check("t6_addr8", 64'(mem_addr), 64'h8);
        check("t6_valid", 64'(if_valid), 64'd1);
        rst = 1'b1;
        mem_ack = 1'b0;
        #1;
        check("t6_req", 64'(mem_req), 64'd0);
        check("t6_addr", 64'(mem_addr), 64'd0);
        check("t6_ivalid", 64'(if_valid), 64'd0);
        check("t6_pc", 64'(if_pc), 64'd0);
        check("t6_inst", 64'(if_inst), 64'd0);
        do_reset();
        wait_req("t6_wreq");
        check("t6_first", 64'(mem_addr), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
